// File: rtl/sd_resp.sv
// SD card SPI-mode response receiver.
// Waits for the card's start bit on DO (bounded by TIMEOUT samples), then
// shifts in an 8-bit R1 or a 40-bit R3/R7 response MSB first. Partial bits
// build up in a shadow shift register; the visible R1/data outputs only
// change when the block enters DONE.
module sd_resp #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isStart,
    input  logic        isLong,
    input  logic        DO,
    output logic        isBusy,
    output logic        isFinish,
    output logic        isTimeout,
    output logic [7:0]  R1,
    output logic [31:0] data
);

    // Wide enough to hold TIMEOUT itself, so the counter never wraps.
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic               long_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic [5:0]         bcnt_q;
    logic [38:0]        shift_q;
    logic               busy_q;
    logic               finish_q;
    logic               timeout_q;
    logic [7:0]         r1_q;
    logic [31:0]        data_q;

    logic [WCNT_W-1:0]  wcnt_d;
    logic [5:0]         bcnt_d;
    logic [39:0]        shift_d;
    logic [5:0]         last_bit;

    // Incremented counters, the shift register with the current DO bit
    // appended, and the bit count at which the response is complete.
    always_comb begin
        wcnt_d   = wcnt_q + 1'b1;
        bcnt_d   = bcnt_q + 1'b1;
        shift_d  = {shift_q, DO};
        last_bit = long_q ? 6'd40 : 6'd8;
    end

    // Capture FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            long_q    <= 1'b0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            timeout_q <= 1'b0;
            r1_q      <= 8'hFF;
            data_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (isStart) begin
                        // Response length is frozen here for the whole capture.
                        long_q  <= isLong;
                        wcnt_q  <= '0;
                        bcnt_q  <= '0;
                        shift_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (!DO) begin
                        // Start bit doubles as R1 bit 7; it wins even on the
                        // final allowed sample.
                        shift_q <= shift_d[38:0];
                        bcnt_q  <= 6'd1;
                        state_q <= RECV;
                    end else begin
                        wcnt_q <= wcnt_d;
                        if (wcnt_d == WCNT_LAST) begin
                            // No response: report 0xFF, keep previous data.
                            r1_q      <= 8'hFF;
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            finish_q  <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                RECV: begin
                    shift_q <= shift_d[38:0];
                    bcnt_q  <= bcnt_d;
                    if (bcnt_d == last_bit) begin
                        if (long_q) begin
                            r1_q   <= shift_d[39:32];
                            data_q <= shift_d[31:0];
                        end else begin
                            r1_q   <= shift_d[7:0];
                        end
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        finish_q  <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Hold the result until the requester drops isStart.
                    if (!isStart) begin
                        finish_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    busy_q   <= 1'b0;
                    finish_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign isBusy    = busy_q;
    assign isFinish  = finish_q;
    assign isTimeout = timeout_q;
    assign R1        = r1_q;
    assign data      = data_q;

endmodule

// File: tb/tb_sd_resp.sv
// Directed bench for sd_resp: expected results are queued when a capture is
// driven and popped when isFinish is seen.
module tb_sd_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        isStart;
    logic        isLong;
    logic        DO;
    logic        isBusy;
    logic        isFinish;
    logic        isTimeout;
    logic [7:0]  R1;
    logic [31:0] data;

    typedef struct packed {
        logic [7:0]  r1;
        logic [31:0] d;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_data;

    sd_resp #(.TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .isStart   (isStart),
        .isLong    (isLong),
        .DO        (DO),
        .isBusy    (isBusy),
        .isFinish  (isFinish),
        .isTimeout (isTimeout),
        .R1        (R1),
        .data      (data)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the finished capture.
    task automatic expect_done(input string tag);
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb: observed %0d queued expected >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_finish"},  {39'b0, isFinish},  40'd1);
            chk({tag, "_busy"},    {39'b0, isBusy},    40'd0);
            chk({tag, "_timeout"}, {39'b0, isTimeout}, {39'b0, e.to});
            chk({tag, "_r1"},      {32'b0, R1},        {32'b0, e.r1});
            chk({tag, "_data"},    {8'b0, data},       {8'b0, e.d});
        end
    endtask

    // One capture: 'highs' idle WAIT samples, then the response bits (MSB is
    // the start bit). isStart/isLong are perturbed mid-capture unless held.
    task automatic capture(input string tag, input logic lng, input int highs,
                           input logic [39:0] v, input bit hold_start);
        int   n;
        exp_t e;
        n = lng ? 40 : 8;
        e.r1 = lng ? v[39:32] : v[7:0];
        e.d  = lng ? v[31:0] : model_data;
        e.to = 1'b0;
        model_data = e.d;
        sb.push_back(e);
        isStart = 1'b1;
        isLong  = lng;
        DO      = 1'b1;
        tick();
        chk({tag, "_busy_start"}, {39'b0, isBusy}, 40'd1);
        if (!hold_start) isStart = 1'b0;
        isLong = ~lng;
        repeat (highs) tick();
        for (int i = n - 1; i >= 0; i--) begin
            DO = v[i];
            tick();
            if (i > 0) chk({tag, "_early_finish"}, {39'b0, isFinish}, 40'd0);
        end
        DO = 1'b1;
        expect_done(tag);
        if (!hold_start) begin
            tick();
            chk({tag, "_idle_finish"}, {39'b0, isFinish}, 40'd0);
            chk({tag, "_r1_hold"}, {32'b0, R1}, {32'b0, e.r1});
        end
    endtask

    initial begin
        exp_t e;
        int   waited;
        reset = 1'b1; isStart = 1'b0; isLong = 1'b0; DO = 1'b1;
        model_data = 32'h0;
        tick();
        chk("rst_busy",    {39'b0, isBusy},    40'd0);
        chk("rst_finish",  {39'b0, isFinish},  40'd0);
        chk("rst_timeout", {39'b0, isTimeout}, 40'd0);
        chk("rst_r1",      {32'b0, R1},        40'hFF);
        chk("rst_data",    {8'b0, data},       40'h0);
        reset = 1'b0;
        tick();

        // Short R1 with 3 idle samples; isStart/isLong changes ignored.
        capture("short", 1'b0, 3, 40'h01, 1'b0);

        // Long R7.
        capture("long", 1'b1, 2, 40'h01_000001AA, 1'b0);

        // Timeout with isStart held high the whole time.
        isStart = 1'b1; isLong = 1'b0; DO = 1'b1;
        tick();
        chk("to_busy_start", {39'b0, isBusy}, 40'd1);
        repeat (63) tick();
        chk("to_63_finish", {39'b0, isFinish}, 40'd0);
        chk("to_63_busy",   {39'b0, isBusy},   40'd1);
        e.r1 = 8'hFF; e.d = model_data; e.to = 1'b1;
        sb.push_back(e);
        waited = 0;
        while (!isFinish && waited < 4) begin
            tick();
            waited++;
        end
        chk("to_latency", waited, 40'd1);
        expect_done("timeout");
        repeat (3) tick();
        chk("hold_finish",  {39'b0, isFinish},  40'd1);
        chk("hold_timeout", {39'b0, isTimeout}, 40'd1);
        chk("hold_r1",      {32'b0, R1},        40'hFF);
        chk("hold_data",    {8'b0, data},       {8'b0, model_data});
        isStart = 1'b0;
        tick();
        chk("release_finish", {39'b0, isFinish}, 40'd0);
        chk("release_busy",   {39'b0, isBusy},   40'd0);

        // Start bit on exactly the 64th WAIT sample.
        capture("edge64", 1'b0, 63, 40'h3C, 1'b0);

        // Asynchronous reset after 20 bits of a long capture.
        isStart = 1'b1; isLong = 1'b1; DO = 1'b1;
        tick();
        isStart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            DO = (i == 0) ? 1'b0 : i[0];
            tick();
        end
        chk("mid_busy", {39'b0, isBusy}, 40'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy",    {39'b0, isBusy},    40'd0);
        chk("arst_finish",  {39'b0, isFinish},  40'd0);
        chk("arst_timeout", {39'b0, isTimeout}, 40'd0);
        chk("arst_r1",      {32'b0, R1},        40'hFF);
        chk("arst_data",    {8'b0, data},       40'h0);
        model_data = 32'h0;
        tick();
        reset = 1'b0;
        DO = 1'b1;
        tick();
        chk("post_rst_busy", {39'b0, isBusy}, 40'd0);
        capture("after_rst", 1'b0, 1, 40'h05, 1'b0);

        chk("sb_empty", sb.size(), 40'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sd_resp.md
SD_RESP -- requirements
Module: SD_RESP

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 64: maximum DO samples taken while waiting for a response start bit (64 = 8 byte times, NCR max).
REQ-002 SHALL provide ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- isStart  input  1  level request to capture one response.
- isLong  input  1  0 = R1 (8 bits); 1 = R3/R7 (40 bits).
- DO  input  1  serial data from card (SPI MISO), idle high, one bit per clk.
- isBusy  output  1  high in WAIT and RECV.
- isFinish  output  1  high in DONE.
- isTimeout  output  1  last capture ended without a start bit.
- R1  output  8  R1 byte of the last completed capture.
- data  output  32  trailing 32 bits of the last long capture.
REQ-003 SHALL use one clock domain (clk) and asynchronous active-high reset (reset).

Function
REQ-004 SHALL implement the states IDLE, WAIT, RECV and DONE, with the outputs specified for each below.
REQ-005 IDLE: when isStart=1 on an edge, the block SHALL latch isLong, clear the wait counter and move to WAIT; otherwise it SHALL stay in IDLE.
REQ-006 WAIT: on each edge the block SHALL sample DO; DO=0 is R1 bit 7 (start bit). It SHALL store the bit, set the bit count to 1 and move to RECV.
REQ-007 WAIT: on each edge with DO=1, the block SHALL increment the wait counter; on the TIMEOUT-th consecutive high sample it SHALL move to DONE with isTimeout=1 and R1=8'hFF, leaving data unchanged.
REQ-008 A DO=0 on the TIMEOUT-th sample SHALL be accepted as the start bit; that sample SHALL NOT be treated as a timeout.
REQ-009 RECV: the block SHALL shift in one DO bit per edge, MSB first.
- First 8 bits SHALL form R1[7:0].
- If long, the next 32 bits SHALL form data[31:0].
REQ-010 RECV: on the edge that samples the final bit (8th if short, 40th if long), the block SHALL move to DONE.
- R1 SHALL update at that edge; data SHALL update at that edge only if long.
- isTimeout SHALL be 0 at that edge.
REQ-011 R1 and data SHALL be assembled in shadow registers; visible R1 and data outputs SHALL change only on entry to DONE.
REQ-012 DONE: isFinish SHALL be 1 and isBusy 0; the block SHALL remain in DONE while isStart=1.
REQ-013 DONE: the block SHALL return to IDLE on the first edge with isStart=0; isFinish SHALL fall at that edge.
REQ-014 isStart deasserted during WAIT or RECV SHALL be ignored; the capture SHALL complete normally.
REQ-015 isLong changes after the IDLE->WAIT edge SHALL be ignored until the next capture.
REQ-016 Latency: isFinish SHALL rise N edges after the start-bit sampling edge, where N = 7 (short) or 39 (long).
REQ-017 The wait counter SHALL be wide enough for TIMEOUT without wrap; the bit counter SHALL be 6 bits and SHALL never exceed 40.
REQ-018 Outputs SHALL be registered; no combinational path from DO to any output.

Reset
REQ-019 On reset=1, the block SHALL go to IDLE immediately, without waiting for clk.
REQ-020 On reset=1, the block SHALL force isBusy=0, isFinish=0, isTimeout=0, R1=8'hFF, data=32'h0, and clear both counters and the shadow registers.
REQ-021 Reset asserted mid-capture SHALL discard all partial bits.
REQ-022 After reset release, the first edge with isStart=1 SHALL start a fresh capture.

Verification
REQ-023 Short R1: isLong=0, DO high for 3 WAIT samples, then 0000_0001 -> isFinish=1, R1=8'h01, isTimeout=0, data=32'h0, 7 edges after the start-bit edge.
REQ-024 Long R7: isLong=1, DO sends 8'h01 then 32'h000001AA -> R1=8'h01, data=32'h000001AA, isFinish 39 edges after the start-bit edge.
REQ-025 Timeout: DO held high, TIMEOUT=64 -> after the 64th WAIT sample isFinish=1, isTimeout=1, R1=8'hFF, data unchanged; a start bit on exactly the 64th sample -> normal capture, isTimeout=0.
REQ-026 Reset mid-RECV: assert reset after 20 bits of a long capture -> immediate IDLE and reset values; next capture of 8'h05 -> R1=8'h05.
REQ-027 Handshake: isStart held high through DONE -> stays DONE with outputs stable; isStart=0 for one edge -> IDLE, isFinish=0; isStart=1 -> new capture, isBusy=1 on the following edge.
